// File: rtl/bm_defs_pkg.sv
// Shared Bomberman definitions.
//   CD_*     : 2-bit facing/direction codes, also used by bomberman_module.
//   BTN_*    : bit positions of the committed button vector (wire order A..Right).
//   max2     : elaboration-time helper for counter sizing.
//   dir_pick : picks the highest-priority direction (U > D > L > R) from a
//              4-bit vector indexed by CD code.
package bm_defs_pkg;

  localparam logic [1:0] CD_U = 2'b00;
  localparam logic [1:0] CD_R = 2'b01;
  localparam logic [1:0] CD_D = 2'b10;
  localparam logic [1:0] CD_L = 2'b11;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Caller guarantees at least one bit of v is set when the result matters.
  function automatic logic [1:0] dir_pick(input logic [3:0] v);
    if (v[CD_U]) return CD_U;
    if (v[CD_D]) return CD_D;
    if (v[CD_L]) return CD_L;
    return CD_R;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk    : destination clock
//   reset  : synchronous, active-high; both flops load RST_VAL
//   i_d    : asynchronous input
//   o_q    : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nes_pad_reader.sv
// NES serial gamepad poller.
// Periodically latches the pad, clocks out 8 active-low bits and commits them
// as direction levels, a facing code and one-shot A/Start pulses.
//   clk, reset          : system clock, synchronous active-high reset
//   pad_data            : serial data from pad (active-low, asynchronous)
//   pad_latch, pad_clk  : registered strobes to the pad, never high together
//   L, R, U, D          : direction levels with opposing pairs cancelled
//   cd                  : facing code (CD_U/CD_R/CD_D/CD_L)
//   bomb_p, start_p     : one-cycle pulses on A / Start press edges
//   btn                 : raw committed buttons, active-high, {R,L,D,U,Start,Sel,B,A}
//   poll_done           : one-cycle pulse in the cycle the outputs change
module nes_pad_reader
  import bm_defs_pkg::*;
#(
  parameter int POLL_DIV  = 1_666_666,
  parameter int LATCH_CYC = 1200,
  parameter int HALF_CYC  = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       L,
  output logic       R,
  output logic       U,
  output logic       D,
  output logic [1:0] cd,
  output logic       bomb_p,
  output logic       start_p,
  output logic [7:0] btn,
  output logic       poll_done
);

  localparam int POLL_W = max2(1, $clog2(POLL_DIV));
  localparam int PH_W   = max2(1, $clog2(max2(LATCH_CYC, HALF_CYC)));

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_WAIT, S_PULSE, S_UPDATE} state_t;

  state_t            r_state, w_state_next;
  logic [POLL_W-1:0] r_poll_cnt;
  logic [PH_W-1:0]   r_phase;
  logic [2:0]        r_idx;
  logic [7:0]        r_shift;
  logic              r_pad_latch, r_pad_clk;
  logic              r_l, r_r, r_u, r_d;
  logic [1:0]        r_cd;
  logic              r_bomb_p, r_start_p, r_poll_done;
  logic [7:0]        r_btn;

  logic              w_sync_q, w_bit, w_tick, w_phase_last;
  logic [3:0]        w_held, w_prev_held, w_new;
  logic [1:0]        w_cd_next;

  // Pad idles high (released), so the synchronizer resets to 1.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (pad_data),
    .o_q   (w_sync_q)
  );
  assign w_bit = ~w_sync_q;

  // Free-running poll timer; its tick is only honoured in IDLE.
  assign w_tick = (r_poll_cnt == POLL_W'(POLL_DIV - 1));
  always_ff @(posedge clk) begin
    if (reset || w_tick) r_poll_cnt <= '0;
    else                 r_poll_cnt <= r_poll_cnt + 1'b1;
  end

  assign w_phase_last = (r_state == S_LATCH) ? (r_phase == PH_W'(LATCH_CYC - 1))
                                             : (r_phase == PH_W'(HALF_CYC - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_state_next = S_LATCH;
      S_LATCH:  if (w_phase_last) w_state_next = S_WAIT;
      S_WAIT:   if (w_phase_last) w_state_next = (r_idx == 3'd7) ? S_UPDATE : S_PULSE;
      S_PULSE:  if (w_phase_last) w_state_next = S_WAIT;
      S_UPDATE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Phase restarts on every state change so each state times itself.
      if (w_state_next != r_state || r_state == S_IDLE) r_phase <= '0;
      else                                              r_phase <= r_phase + 1'b1;
      if (r_state == S_PULSE && w_phase_last) r_idx <= r_idx + 1'b1;
      else if (r_state == S_UPDATE)           r_idx <= '0;
      // Sample only at the very end of the low half, after the pad has settled.
      if (r_state == S_WAIT && w_phase_last) r_shift[r_idx] <= w_bit;
      // Strobes decode the next state so they are clean flop outputs.
      r_pad_latch <= (w_state_next == S_LATCH);
      r_pad_clk   <= (w_state_next == S_PULSE);
    end
  end

  // Direction vectors indexed by CD code, opposing pairs cancelled.
  assign w_held[CD_U] = r_shift[BTN_UP]    & ~r_shift[BTN_DOWN];
  assign w_held[CD_D] = r_shift[BTN_DOWN]  & ~r_shift[BTN_UP];
  assign w_held[CD_L] = r_shift[BTN_LEFT]  & ~r_shift[BTN_RIGHT];
  assign w_held[CD_R] = r_shift[BTN_RIGHT] & ~r_shift[BTN_LEFT];
  assign w_prev_held[CD_U] = r_u;
  assign w_prev_held[CD_D] = r_d;
  assign w_prev_held[CD_L] = r_l;
  assign w_prev_held[CD_R] = r_r;
  assign w_new = w_held & ~w_prev_held;

  // A fresh press wins; otherwise keep facing while it is held; otherwise
  // fall back to any held direction; with nothing held keep the last facing.
  always_comb begin
    w_cd_next = r_cd;
    if (|w_new)               w_cd_next = dir_pick(w_new);
    else if (w_held[r_cd])    w_cd_next = r_cd;
    else if (|w_held)         w_cd_next = dir_pick(w_held);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn       <= '0;
      r_l         <= 1'b0;
      r_r         <= 1'b0;
      r_u         <= 1'b0;
      r_d         <= 1'b0;
      r_cd        <= CD_D;
      r_bomb_p    <= 1'b0;
      r_start_p   <= 1'b0;
      r_poll_done <= 1'b0;
    end else begin
      r_bomb_p    <= 1'b0;
      r_start_p   <= 1'b0;
      r_poll_done <= 1'b0;
      if (r_state == S_UPDATE) begin
        r_btn       <= r_shift;
        r_u         <= w_held[CD_U];
        r_d         <= w_held[CD_D];
        r_l         <= w_held[CD_L];
        r_r         <= w_held[CD_R];
        r_cd        <= w_cd_next;
        r_bomb_p    <= r_shift[BTN_A]     & ~r_btn[BTN_A];
        r_start_p   <= r_shift[BTN_START] & ~r_btn[BTN_START];
        r_poll_done <= 1'b1;
      end
    end
  end

  assign pad_latch = r_pad_latch;
  assign pad_clk   = r_pad_clk;
  assign L         = r_l;
  assign R         = r_r;
  assign U         = r_u;
  assign D         = r_d;
  assign cd        = r_cd;
  assign bomb_p    = r_bomb_p;
  assign start_p   = r_start_p;
  assign btn       = r_btn;
  assign poll_done = r_poll_done;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader: a behavioural 4021-style pad model,
// a reference model computing expected commits at each latch, and a monitor
// comparing every poll_done against the queued expectation.
module tb_nes_pad_reader;
  import bm_defs_pkg::*;

  localparam int POLL_DIV  = 400;
  localparam int LATCH_CYC = 12;
  localparam int HALF_CYC  = 6;
  localparam int LAT       = LATCH_CYC + 16 * HALF_CYC - HALF_CYC + 1;  // 103
  localparam int NPULSE    = 7;  // 8 bits need 7 shift clocks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data = 1'b1;
  logic       pad_latch, pad_clk, L, R, U, D, bomb_p, start_p, poll_done;
  logic [1:0] cd;
  logic [7:0] btn;

  nes_pad_reader #(
    .POLL_DIV  (POLL_DIV),
    .LATCH_CYC (LATCH_CYC),
    .HALF_CYC  (HALF_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .L         (L),
    .R         (R),
    .U         (U),
    .D         (D),
    .cd        (cd),
    .bomb_p    (bomb_p),
    .start_p   (start_p),
    .btn       (btn),
    .poll_done (poll_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] btn;
    logic [3:0] lrud;   // {L,R,U,D}
    logic [1:0] cd;
    logic       bomb;
    logic       start;
    int         done_cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] m_prev;    // held directions of previous commit, indexed by CD code
  logic [1:0] m_cd;
  logic [7:0] m_bprev;
  logic [7:0] pad_btn = 8'h00;

  function automatic void model_reset();
    m_prev  = '0;
    m_cd    = CD_D;
    m_bprev = '0;
  endfunction

  function automatic void model_poll(input logic [7:0] b, input int dcyc);
    exp_t       e;
    logic [3:0] h, nw;
    int         pick;
    int         prio[4];
    prio = '{0, 2, 3, 1};  // U, D, L, R as CD codes
    h[0] = b[4] && !b[5];
    h[2] = b[5] && !b[4];
    h[3] = b[6] && !b[7];
    h[1] = b[7] && !b[6];
    nw   = h & ~m_prev;
    pick = -1;
    for (int k = 0; k < 4; k++) if (pick < 0 && nw[prio[k]]) pick = prio[k];
    if (pick < 0 && !h[m_cd])
      for (int k = 0; k < 4; k++) if (pick < 0 && h[prio[k]]) pick = prio[k];
    if (pick >= 0) m_cd = 2'(pick);
    e.btn      = b;
    e.lrud     = {h[3], h[1], h[0], h[2]};
    e.cd       = m_cd;
    e.bomb     = b[0] && !m_bprev[0];
    e.start    = b[3] && !m_bprev[3];
    e.done_cyc = dcyc;
    sbq.push_back(e);
    m_prev  = h;
    m_bprev = b;
  endfunction

  // ---------------- pad model ----------------
  // Parallel load while latched; shift on clock rise. The wire shows junk
  // for the first part of each high phase and the real bit from mid-pulse on.
  logic [7:0] pad_cap = 8'h00;
  int         pad_hi = 0;
  always @(negedge clk) begin
    if (pad_latch) begin
      pad_cap  = pad_btn;
      pad_data = ~pad_cap[0];
      pad_hi   = 0;
    end else if (pad_clk) begin
      pad_hi++;
      if (pad_hi == 1) begin
        pad_cap  = {1'b0, pad_cap[7:1]};
        pad_data = 1'($urandom_range(0, 1));
      end else if (pad_hi == 3) begin
        pad_data = ~pad_cap[0];
      end
    end else begin
      pad_hi = 0;
    end
  end

  // ---------------- monitor ----------------
  int   done_cnt = 0;
  int   exp_latch = 0;
  int   lat_w, pulses, bad, ovl, hi_run, lo_run, stray;
  logic prev_latch, prev_pclk;
  exp_t e_cur;

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      model_reset();
      exp_latch  = cyc + POLL_DIV + 1;
      lat_w = 0; pulses = 0; bad = 0; ovl = 0; hi_run = 0; lo_run = 0; stray = 0;
      prev_latch = 1'b0;
      prev_pclk  = 1'b0;
    end else begin
      if (pad_latch && !prev_latch) begin
        chk("latch_start_cycle", cyc, exp_latch);
        exp_latch = cyc + POLL_DIV;
        model_poll(pad_btn, cyc + LAT);
        lat_w = 0; pulses = 0; bad = 0; ovl = 0; hi_run = 0; lo_run = 0;
      end
      if (pad_latch && pad_clk) ovl++;
      if (pad_latch) begin
        lat_w++;
        lo_run = 0;
      end else if (pad_clk) begin
        if (!prev_pclk) begin
          pulses++;
          if (lo_run != HALF_CYC) bad++;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_pclk) begin
          if (hi_run != HALF_CYC) bad++;
          lo_run = 0;
        end
        lo_run++;
      end

      if (poll_done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL sb_empty: got poll_done, expected no commit (cycle %0d)", cyc);
        end else begin
          e_cur = sbq.pop_front();
          $display("[TB] poll %0d: btn=%02h LRUD=%b cd=%b bomb=%b start=%b", done_cnt,
                   btn, {L, R, U, D}, cd, bomb_p, start_p);
          chk("btn", btn, e_cur.btn);
          chk("lrud", {L, R, U, D}, e_cur.lrud);
          chk("cd", cd, e_cur.cd);
          chk("bomb_start", {bomb_p, start_p}, {e_cur.bomb, e_cur.start});
          chk("latency", cyc, e_cur.done_cyc);
          chk("latch_width", lat_w, LATCH_CYC);
          chk("clk_pulses", pulses, NPULSE);
          chk("clk_timing", bad, 0);
          chk("latch_clk_overlap", ovl, 0);
          chk("stray_pulse", stray, 0);
          stray = 0;
        end
      end else if (bomb_p || start_p) begin
        stray++;
      end
      prev_latch = pad_latch;
      prev_pclk  = pad_clk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_poll(input logic [7:0] b);
    int start_cnt;
    int n;
    pad_btn   = b;
    start_cnt = done_cnt;
    n         = 0;
    while (done_cnt == start_cnt && n < 1000) begin
      step();
      n++;
    end
    if (done_cnt == start_cnt) begin
      tests++;
      fails++;
      $display("[TB] FAIL poll_timeout: got no poll_done in %0d cycles, expected one", n);
    end
  endtask

  logic [7:0] dir_seq[13];
  logic [7:0] cur;
  int         n;

  initial begin
    dir_seq = '{8'h00, 8'h80, 8'h90, 8'h80, 8'h30, 8'hC0,
                8'h01, 8'h01, 8'h01, 8'h00, 8'h08, 8'h08, 8'h08};
    reset = 1'b1;
    repeat (3) step();
    chk("reset_state",
        {pad_latch, pad_clk, L, R, U, D, cd, bomb_p, start_p, btn, poll_done},
        {2'b00, 4'b0000, CD_D, 2'b00, 8'h00, 1'b0});
    reset = 1'b0;

    foreach (dir_seq[i]) run_poll(dir_seq[i]);

    cur = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) cur = 8'($urandom);
      run_poll(cur);
    end

    // Abort a poll while bit 4 is being clocked.
    pad_btn = 8'hE7;
    n = 0;
    while (!pad_latch && n < 1000) begin
      step();
      n++;
    end
    chk("abort_latch_seen", pad_latch, 1'b1);
    repeat (67) step();
    chk("abort_in_pulse", pad_clk, 1'b1);
    reset = 1'b1;
    step();
    chk("abort_reset_state",
        {pad_latch, pad_clk, L, R, U, D, cd, bomb_p, start_p, btn, poll_done},
        {2'b00, 4'b0000, CD_D, 2'b00, 8'h00, 1'b0});
    reset = 1'b0;
    run_poll(8'h5A);
    run_poll(8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
